// File: rtl/viterbi_pkg.sv
// ---------------------------------------------------------------------------
// viterbi_pkg
// Shared definitions for the Viterbi traceback-block sequencer:
//   - state_e      : sequencer state encoding
//   - DEF_*        : default traceback block size and ACS launch phases
//   - nb_width()   : width of the block counters (one more bit than the
//                    number of whole blocks an ADDR_W-bit frame can hold,
//                    so a trailing partial block still fits)
// ---------------------------------------------------------------------------
package viterbi_pkg;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_WAIT_ACS = 3'd2,
    ST_READ     = 3'd3,
    ST_TRACE    = 3'd4,
    ST_RESTART  = 3'd5,
    ST_DRAIN    = 3'd6,
    ST_DONE     = 3'd7
  } state_e;

  localparam int DEF_TB_LEN_LOG2 = 7;
  localparam int DEF_ACS_FIRST   = 13;
  localparam int DEF_ACS_NEXT    = 15;

  function automatic int nb_width(input int addr_w, input int tb_len_log2);
    return addr_w - tb_len_log2 + 1;
  endfunction

endpackage

// File: rtl/viterbi_tb_sequencer_if.sv
// ---------------------------------------------------------------------------
// viterbi_tb_sequencer_if
// Bundles everything between the traceback sequencer and its surroundings.
//   master : the datapath/environment side (drives stream and engine status)
//   slave  : the sequencer side (drives strobes, resets and frame status)
// Signals:
//   valid_in, write_address      input symbol stream and its bit count
//   acs_counter                  current ACS phase
//   tb_busy, tb_stop, tb_valid_out traceback engine status
//   out_enable                   downstream reader ready
//   reset_viterbi (active-low), active, re, re_buffer,
//   max_read_address, block_count, done, overrun
// ---------------------------------------------------------------------------
interface viterbi_tb_sequencer_if
  import viterbi_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int TB_LEN_LOG2 = DEF_TB_LEN_LOG2,
  parameter int ACS_CNT_W   = 4
);

  logic                                      valid_in;
  logic [ADDR_W-1:0]                         write_address;
  logic [ACS_CNT_W-1:0]                      acs_counter;
  logic                                      tb_busy;
  logic                                      tb_stop;
  logic                                      tb_valid_out;
  logic                                      out_enable;

  logic                                      reset_viterbi;
  logic                                      active;
  logic                                      re;
  logic                                      re_buffer;
  logic [ADDR_W-2:0]                         max_read_address;
  logic [nb_width(ADDR_W, TB_LEN_LOG2)-1:0]  block_count;
  logic                                      done;
  logic                                      overrun;

  modport master (
    output valid_in, write_address, acs_counter, tb_busy, tb_stop,
           tb_valid_out, out_enable,
    input  reset_viterbi, active, re, re_buffer, max_read_address,
           block_count, done, overrun
  );

  modport slave (
    input  valid_in, write_address, acs_counter, tb_busy, tb_stop,
           tb_valid_out, out_enable,
    output reset_viterbi, active, re, re_buffer, max_read_address,
           block_count, done, overrun
  );

endinterface

// File: rtl/viterbi_edge_det.sv
// ---------------------------------------------------------------------------
// viterbi_edge_det
// Registered rise/fall detector. The previous value is held in a flop; the
// edge outputs compare it with the live input, so an edge is visible in the
// cycle the new level is sampled.
// Ports:
//   clk    clock
//   reset  asynchronous, active-low
//   sig    monitored level
//   rise   sig is 1 now and was 0 last cycle
//   fall   sig is 0 now and was 1 last cycle
// ---------------------------------------------------------------------------
module viterbi_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev <= 1'b0;
    else        prev <= sig;
  end

  assign rise = sig & ~prev;
  assign fall = ~sig & prev;

endmodule

// File: rtl/viterbi_tb_sequencer.sv
// ---------------------------------------------------------------------------
// viterbi_tb_sequencer
// Traceback-block sequencer for the WiFi PHY Viterbi decoder. Captures the
// frame length when valid_in falls, splits the frame into 2^TB_LEN_LOG2-bit
// traceback blocks, launches one read strobe per block on the right ACS
// phase, pulses the decoder reset between blocks and finally releases the
// output buffer to the downstream reader.
//
// Ports:
//   clk    clock
//   reset  asynchronous, active-low
//   bus    viterbi_tb_sequencer_if.slave (stream, engine status, strobes,
//          frame status; see the interface for the signal list)
//
// Build option:
//   VITERBI_TB_PARTIAL_BLOCK_EN  defined   : a trailing partial block is
//                                            traced back too (ceil)
//                                undefined : whole blocks only (floor)
// ---------------------------------------------------------------------------
module viterbi_tb_sequencer
  import viterbi_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int TB_LEN_LOG2 = DEF_TB_LEN_LOG2,
  parameter int ACS_CNT_W   = 4,
  parameter int ACS_FIRST   = DEF_ACS_FIRST,
  parameter int ACS_NEXT    = DEF_ACS_NEXT
) (
  input  logic                    clk,
  input  logic                    reset,
  viterbi_tb_sequencer_if.slave   bus
);

  localparam int NB_W  = nb_width(ADDR_W, TB_LEN_LOG2);
  localparam int MRA_W = ADDR_W - 1;

  localparam logic [ACS_CNT_W-1:0] ACS_FIRST_V = ACS_FIRST[ACS_CNT_W-1:0];
  localparam logic [ACS_CNT_W-1:0] ACS_NEXT_V  = ACS_NEXT[ACS_CNT_W-1:0];

  // Plain vectors keep the state register compatible with existing
  // netlists and probes that expect a 3-bit code.
  localparam logic [2:0] S_INIT     = ST_INIT;
  localparam logic [2:0] S_COLLECT  = ST_COLLECT;
  localparam logic [2:0] S_WAIT_ACS = ST_WAIT_ACS;
  localparam logic [2:0] S_READ     = ST_READ;
  localparam logic [2:0] S_TRACE    = ST_TRACE;
  localparam logic [2:0] S_RESTART  = ST_RESTART;
  localparam logic [2:0] S_DRAIN    = ST_DRAIN;
  localparam logic [2:0] S_DONE     = ST_DONE;

  logic [2:0]        state;
  logic              seen_in;
  logic [ADDR_W-1:0] total;
  logic [NB_W-1:0]   num_blocks;

  logic [NB_W-1:0]   num_blocks_calc;
  logic [MRA_W-1:0]  half_total;
  logic [MRA_W-1:0]  mra_calc;
  logic              first_block;
  logic              launch;

  logic vin_rise;
  logic vin_fall;
  logic tbv_fall;
  logic tbv_rise_unused;  // start of a burst carries no meaning here

  viterbi_edge_det u_vin_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (bus.valid_in),
    .rise  (vin_rise),
    .fall  (vin_fall)
  );

  viterbi_edge_det u_tbv_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (bus.tb_valid_out),
    .rise  (tbv_rise_unused),
    .fall  (tbv_fall)
  );

  // Block count for the frame length currently on write_address.
  always_comb begin
    // NOTE: every variable written here gets a value before any condition,
    // otherwise the untaken paths would infer a latch.
    num_blocks_calc = NB_W'(bus.write_address >> TB_LEN_LOG2);
`ifdef VITERBI_TB_PARTIAL_BLOCK_EN
    if (bus.write_address[TB_LEN_LOG2-1:0] != '0)
      num_blocks_calc = num_blocks_calc + NB_W'(1);
`endif
  end

  // Decoded bits are packed two per output-buffer word; the last address
  // is one below the word count, clamped at zero for tiny frames.
  always_comb begin
    half_total = total[ADDR_W-1:1];
    mra_calc   = (half_total == '0) ? '0 : half_total - MRA_W'(1);
  end

  // The first block waits for the datapath to leave its stall; later blocks
  // only need the engine idle.
  always_comb begin
    first_block = (bus.block_count == '0);
    if (first_block)
      launch = (bus.acs_counter == ACS_FIRST_V) && !bus.tb_stop && !bus.tb_busy;
    else
      launch = (bus.acs_counter == ACS_NEXT_V) && !bus.tb_busy;
  end

  // NOTE: state and outputs are flops, so they use non-blocking assignment;
  // every flop reads the pre-edge value of its peers regardless of order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= S_INIT;
      seen_in              <= 1'b0;
      total                <= '0;
      num_blocks           <= '0;
      bus.reset_viterbi    <= 1'b0;
      bus.active           <= 1'b0;
      bus.re               <= 1'b0;
      bus.re_buffer        <= 1'b0;
      bus.max_read_address <= '0;
      bus.block_count      <= '0;
      bus.done             <= 1'b0;
      bus.overrun          <= 1'b0;
    end else begin
      bus.re <= 1'b0;

      // A new frame may only start from COLLECT or DONE; anywhere else the
      // rise is flagged and otherwise dropped.
      if (vin_rise && (state inside {S_WAIT_ACS, S_READ, S_TRACE, S_RESTART, S_DRAIN}))
        bus.overrun <= 1'b1;

      case (state)
        S_INIT: begin
          bus.reset_viterbi <= 1'b1;
          state             <= S_COLLECT;
        end

        S_COLLECT: begin
          if (vin_rise) seen_in <= 1'b1;
          if (seen_in && vin_fall) begin
            seen_in    <= 1'b0;
            total      <= bus.write_address;
            num_blocks <= num_blocks_calc;
            state      <= (num_blocks_calc == '0) ? S_DRAIN : S_WAIT_ACS;
          end
        end

        S_WAIT_ACS: begin
          if (launch) begin
            bus.re <= 1'b1;
            state  <= S_READ;
          end
        end

        S_READ: begin
          bus.active <= 1'b1;
          state      <= S_TRACE;
        end

        S_TRACE: begin
          if (tbv_fall) begin
            bus.block_count   <= bus.block_count + NB_W'(1);
            bus.reset_viterbi <= 1'b0;
            bus.active        <= 1'b0;
            state             <= S_RESTART;
          end else if (bus.tb_busy) begin
            bus.active <= 1'b0;
          end
        end

        S_RESTART: begin
          bus.reset_viterbi <= 1'b1;
          state <= (bus.block_count == num_blocks) ? S_DRAIN : S_WAIT_ACS;
        end

        S_DRAIN: begin
          bus.max_read_address <= mra_calc;
          if (bus.out_enable) begin
            bus.re_buffer <= 1'b1;
            bus.done      <= 1'b1;
            state         <= S_DONE;
          end
        end

        S_DONE: begin
          if (vin_rise) begin
            bus.done        <= 1'b0;
            bus.re_buffer   <= 1'b0;
            bus.block_count <= '0;
            seen_in         <= 1'b1;
            state           <= S_COLLECT;
          end
        end

        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_tb_sequencer.sv
// ---------------------------------------------------------------------------
// tb_viterbi_tb_sequencer
// Directed bench for viterbi_tb_sequencer. The bench plays the ACS/traceback
// datapath and the downstream reader; outputs are sampled on the falling
// clock edge and inputs are driven right after sampling.
// Expected block counts follow VITERBI_TB_PARTIAL_BLOCK_EN if it is defined.
// ---------------------------------------------------------------------------
module tb_viterbi_tb_sequencer;
  import viterbi_pkg::*;

  localparam int ADDR_W      = 15;
  localparam int TB_LEN_LOG2 = DEF_TB_LEN_LOG2;
  localparam int ACS_CNT_W   = 4;

`ifdef VITERBI_TB_PARTIAL_BLOCK_EN
  localparam int NB300 = 3;
`else
  localparam int NB300 = 2;
`endif

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;

  viterbi_tb_sequencer_if #(
    .ADDR_W      (ADDR_W),
    .TB_LEN_LOG2 (TB_LEN_LOG2),
    .ACS_CNT_W   (ACS_CNT_W)
  ) bus ();

  viterbi_tb_sequencer #(
    .ADDR_W      (ADDR_W),
    .TB_LEN_LOG2 (TB_LEN_LOG2),
    .ACS_CNT_W   (ACS_CNT_W),
    .ACS_FIRST   (DEF_ACS_FIRST),
    .ACS_NEXT    (DEF_ACS_NEXT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic negc();
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_reset_viterbi"}, 32'(bus.reset_viterbi), 0);
    check({tag, "_active"},        32'(bus.active), 0);
    check({tag, "_re"},            32'(bus.re), 0);
    check({tag, "_re_buffer"},     32'(bus.re_buffer), 0);
    check({tag, "_mra"},           32'(bus.max_read_address), 0);
    check({tag, "_block_count"},   32'(bus.block_count), 0);
    check({tag, "_done"},          32'(bus.done), 0);
    check({tag, "_overrun"},       32'(bus.overrun), 0);
  endtask

  // Raise valid_in, confirm the frame status is cleared, then drop valid_in
  // with the final bit count on write_address.
  task automatic start_frame(input string tag, input logic [ADDR_W-1:0] addr);
    bus.write_address = '0;
    bus.valid_in      = 1'b1;
    negc();
    check({tag, "_start_done"},      32'(bus.done), 0);
    check({tag, "_start_re_buffer"}, 32'(bus.re_buffer), 0);
    check({tag, "_start_bc"},        32'(bus.block_count), 0);
    negc();
    bus.write_address = addr;
    bus.valid_in      = 1'b0;
  endtask

  // Sweep the ACS phase from 0 until re appears, then act as the traceback
  // engine for one block.
  task automatic run_block(input string tag, input logic hold_stop,
                           input logic [3:0] exp_acs, input logic pulse_valid,
                           input int exp_bc);
    logic [3:0] drive;
    logic       seen;
    logic [3:0] launched;
    int         at;
    drive    = '0;
    seen     = 1'b0;
    launched = '0;
    at       = -1;
    bus.tb_busy     = 1'b0;
    bus.tb_stop     = hold_stop;
    bus.acs_counter = drive;
    for (int i = 0; i < 80 && !seen; i++) begin
      negc();
      if (bus.re) begin
        seen     = 1'b1;
        launched = drive;
        at       = i;
      end else begin
        drive           = drive + 4'd1;
        bus.acs_counter = drive;
        if (hold_stop && i == 20) bus.tb_stop = 1'b0;
      end
    end
    check({tag, "_re_seen"}, 32'(seen), 1);
    check({tag, "_launch_acs"}, 32'(launched), 32'(exp_acs));
    if (hold_stop) check({tag, "_stop_held"}, 32'(at > 20), 1);

    negc();
    check({tag, "_re_one_cycle"}, 32'(bus.re), 0);
    check({tag, "_active_up"},    32'(bus.active), 1);
    bus.tb_busy      = 1'b1;
    bus.tb_valid_out = 1'b1;
    negc();
    check({tag, "_active_down"}, 32'(bus.active), 0);
    check({tag, "_rv_high"},     32'(bus.reset_viterbi), 1);
    if (pulse_valid) begin
      bus.valid_in      = 1'b1;
      bus.write_address = 15'd1024;
      negc();
      bus.valid_in = 1'b0;
      negc();
      check({tag, "_overrun_set"}, 32'(bus.overrun), 1);
    end
    negc();
    bus.tb_valid_out = 1'b0;
    bus.tb_busy      = 1'b0;
    negc();
    check({tag, "_rv_low"},  32'(bus.reset_viterbi), 0);
    check({tag, "_bc"},      32'(bus.block_count), 32'(exp_bc));
    negc();
    check({tag, "_rv_back"}, 32'(bus.reset_viterbi), 1);
  endtask

  // Stay in DRAIN with ACS phases running, then hand over the buffer.
  task automatic expect_drain(input string tag, input int exp_mra, input int exp_bc);
    logic [3:0] drive;
    int         stray;
    drive = '0;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      bus.acs_counter = drive;
      negc();
      if (bus.re) stray++;
      drive = drive + 4'd1;
    end
    check({tag, "_stray_re"},      32'(stray), 0);
    check({tag, "_drain_done"},    32'(bus.done), 0);
    check({tag, "_drain_rebuf"},   32'(bus.re_buffer), 0);
    bus.out_enable = 1'b1;
    negc();
    check({tag, "_re_buffer"},     32'(bus.re_buffer), 1);
    check({tag, "_done"},          32'(bus.done), 1);
    check({tag, "_mra"},           32'(bus.max_read_address), 32'(exp_mra));
    check({tag, "_final_bc"},      32'(bus.block_count), 32'(exp_bc));
    bus.out_enable = 1'b0;
    negc();
    check({tag, "_rebuf_hold"},    32'(bus.re_buffer), 1);
  endtask

  initial begin
    reset             = 1'b0;
    bus.valid_in      = 1'b0;
    bus.write_address = '0;
    bus.acs_counter   = '0;
    bus.tb_busy       = 1'b0;
    bus.tb_stop       = 1'b0;
    bus.tb_valid_out  = 1'b0;
    bus.out_enable    = 1'b0;

    // Power-on reset.
    repeat (3) negc();
    check_reset_vals("por");
    reset = 1'b1;
    #1;
    check("por_rv_init", 32'(bus.reset_viterbi), 0);
    negc();
    check("por_rv_collect", 32'(bus.reset_viterbi), 1);

    // 256 bits: two blocks; first launch held off by tb_stop, second on 15.
    start_frame("f256", 15'd256);
    run_block("f256_b0", 1'b1, 4'd13, 1'b0, 1);
    run_block("f256_b1", 1'b0, 4'd15, 1'b0, 2);
    expect_drain("f256", 127, 2);

    // 300 bits: trailing partial block depends on the build option.
    start_frame("f300", 15'd300);
    for (int b = 0; b < NB300; b++)
      run_block($sformatf("f300_b%0d", b), 1'b0, (b == 0) ? 4'd13 : 4'd15, 1'b0, b + 1);
    expect_drain("f300", 149, NB300);

    // Empty frame: straight to DRAIN.
    start_frame("f0", 15'd0);
    expect_drain("f0", 0, 0);
    check("f0_overrun_clear", 32'(bus.overrun), 0);

    // 128 bits with a stray valid_in pulse during TRACE.
    start_frame("f128", 15'd128);
    run_block("f128_b0", 1'b0, 4'd13, 1'b1, 1);
    expect_drain("f128", 63, 1);
    check("f128_overrun_sticky", 32'(bus.overrun), 1);

    // Reset in the middle of a TRACE.
    start_frame("frst", 15'd256);
    bus.acs_counter = 4'd13;
    begin
      logic got;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
        negc();
        if (bus.re) got = 1'b1;
      end
      check("frst_re_seen", 32'(got), 1);
    end
    negc();
    check("frst_in_trace", 32'(bus.active), 1);
    #2;
    reset           = 1'b0;
    bus.acs_counter = '0;
    #1;
    check_reset_vals("midrst");
    negc();
    reset = 1'b1;
    #1;
    check("midrst_rv_init", 32'(bus.reset_viterbi), 0);
    negc();
    check("midrst_rv_collect", 32'(bus.reset_viterbi), 1);

    // The block recovers and handles a fresh frame.
    start_frame("frec", 15'd0);
    expect_drain("frec", 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/viterbi_tb_sequencer.md
# viterbi_tb_sequencer

Parametrised traceback-block sequencer for the WiFi PHY Viterbi decoder. It captures the frame length from the input write address, splits the frame into traceback blocks of 2^TB_LEN_LOG2 bits, and issues one read strobe per block aligned to the ACS cycle. Between blocks it pulses the decoder reset, and at end of frame it hands the output buffer to the downstream reader. It sits between the ACS/traceback datapath and the decoded-bit output buffer.

## Interface
- ADDR_W, 15: write address width.
- TB_LEN_LOG2, 7: log2 of traceback block length; 7 gives 128 bits.
- ACS_CNT_W, 4: ACS counter width.
- ACS_FIRST, 13: ACS phase that launches the first block.
- ACS_NEXT, 15: ACS phase that launches every later block.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- valid_in  in  1  input symbol stream active. Its falling edge marks end of frame.
- write_address  in  ADDR_W  bits written; sampled on the valid_in falling edge.
- acs_counter  in  ACS_CNT_W  current ACS phase.
- tb_busy  in  1  traceback engine running.
- tb_stop  in  1  traceback stalled; blocks the first launch only.
- tb_valid_out  in  1  traceback output burst. Its falling edge marks block finished.
- out_enable  in  1  downstream reader ready.
- reset_viterbi  out  1  active-low decoder reset.
- active  out  1  traceback requested.
- re  out  1  one-cycle read strobe.
- re_buffer  out  1  output buffer released to reader.
- max_read_address  out  ADDR_W-1  last valid output-buffer address.
- block_count  out  ADDR_W-TB_LEN_LOG2+1  blocks completed.
- done  out  1  frame fully decoded.
- overrun  out  1  sticky flag: valid_in rose while a frame was in flight.

## Operation
- States and transitions:
  - INIT → COLLECT after 1 cycle.
  - COLLECT → WAIT_ACS, or → DRAIN when num_blocks==0.
  - WAIT_ACS → READ.
  - READ → TRACE.
  - TRACE → RESTART.
  - RESTART → WAIT_ACS, or → DRAIN after the last block.
  - DRAIN → DONE.
  - DONE → COLLECT on a valid_in rise.
- INIT: reset_viterbi driven 0. It goes to 1 on the transition to COLLECT.
- COLLECT: a valid_in rise sets seen_in. When valid_in is 0 and seen_in is set, the block latches total=write_address and computes num_blocks = total>>TB_LEN_LOG2, plus 1 if the low TB_LEN_LOG2 bits are nonzero (only when the macro is defined).
- WAIT_ACS, first block: launch when acs_counter==ACS_FIRST && !tb_stop && !tb_busy.
- WAIT_ACS, later blocks: launch when acs_counter==ACS_NEXT && !tb_busy.
- READ: re=1 for exactly 1 cycle.
- TRACE:
  - active=1 from the cycle after re until the first cycle tb_busy is sampled 1.
  - On the tb_valid_out falling edge: block_count++ and reset_viterbi=0.
- RESTART: reset_viterbi returns to 1 after exactly 1 low cycle. Then go to DRAIN if block_count==num_blocks, else WAIT_ACS.
- DRAIN:
  - max_read_address = (total>>1)-1, saturating at 0 when total<2.
  - Hold in DRAIN until out_enable=1, then re_buffer=1.
- DONE:
  - done=1; re_buffer and max_read_address hold.
  - A valid_in rise clears done, re_buffer and block_count, sets seen_in, and goes to COLLECT.
- overrun: set when valid_in rises in WAIT_ACS, READ, TRACE, RESTART or DRAIN. The rise is otherwise ignored. Cleared only by reset.
- Asynchronous reset mid-operation: all state is discarded and the block re-enters INIT.

## Timing
- Reset values: reset_viterbi=0, active=0, re=0, re_buffer=0, max_read_address=0, block_count=0, done=0, overrun=0.
- Edge detects use registered previous values. COLLECT exit happens the cycle after valid_in is sampled 0.
- re is asserted the cycle after the launch condition is sampled true.
- active rises 1 cycle after re.
- reset_viterbi is low exactly 1 cycle, starting the cycle after tb_valid_out is sampled 0 following a 1.
- re_buffer rises 1 cycle after out_enable is sampled 1 in DRAIN.
- Launch condition and tb_valid_out falling edge in the same cycle: the falling edge is handled first; the launch waits for the next matching ACS phase.
- block_count wraps modulo its width. This cannot happen in practice, since num_blocks ≤ 2^(ADDR_W-TB_LEN_LOG2).

## Configuration
- VITERBI_TB_PARTIAL_BLOCK_EN defined: a trailing partial block counts as a block (ceil). Example: 300 bits gives 3 blocks.
- Undefined: floor only; trailing bits are not traced back. Example: 300 bits gives 2 blocks.
- max_read_address is unaffected by the macro.

## Structure
- Package viterbi_pkg holds:
  - the state enum;
  - default TB_LEN_LOG2, ACS_FIRST and ACS_NEXT;
  - the num_blocks width function.
- Sub-module viterbi_edge_det, instanced twice (valid_in, tb_valid_out): registered rise/fall detect with async active-low reset.

## Test plan
All cases use defaults with the macro defined unless stated.
- write_address=256 → 2 re pulses, 2 one-cycle reset_viterbi lows, block_count=2, max_read_address=127; re_buffer rises 1 cycle after out_enable=1.
- write_address=300 → 3 blocks, max_read_address=149. With the macro undefined → 2 blocks, max_read_address=149.
- First block with acs_counter=13 and tb_stop=1 → no re. Drop tb_stop → re the cycle after the next acs_counter=13. Second block ignores 13 and launches on 15.
- write_address=0 → no re, direct to DRAIN, max_read_address=0, done after out_enable.
- Reset asserted in TRACE → all outputs at reset values. After release, reset_viterbi=0 for 1 cycle, then 1.
- valid_in pulsed during TRACE → overrun=1, block_count and num_blocks unchanged.
